control_unit_fsm: RTL and testbench

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

---
 rtl/control_unit_fsm.sv | 159 +++++++++++++++
 tb/tb_control_unit_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Multi-cycle control FSM for a small MIPS-like core.
// Define CU_JUMP_EN to enable j/jal/jr; otherwise they decode as illegal.
module control_unit_fsm (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_B  = 3'b101,
    S_EXE_A  = 3'b110,
    S_WB_A   = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_HALT  = 6'b111111;
`ifdef CU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
`endif

  state_e state_q, state_d;

  logic is_r, is_i, is_lw, is_sw;
  logic is_beq, is_bne, is_halt;
  logic is_j, is_jal, is_jr;
  logic is_alu, is_jump, illegal;

  always_comb begin
    is_r    = 1'b0;
    is_i    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_halt = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    ALUOp   = 3'b000;
    case (op)
      OP_ADD:   is_r = 1'b1;
      OP_SUB:   begin is_r = 1'b1; ALUOp = 3'b001; end
      OP_AND:   begin is_r = 1'b1; ALUOp = 3'b100; end
      OP_OR:    begin is_r = 1'b1; ALUOp = 3'b011; end
      OP_ADDIU: is_i = 1'b1;
      OP_ANDI:  begin is_i = 1'b1; ALUOp = 3'b100; end
      OP_ORI:   begin is_i = 1'b1; ALUOp = 3'b011; end
      OP_SLTI:  begin is_i = 1'b1; ALUOp = 3'b110; end
      OP_LW:    is_lw = 1'b1;
      OP_SW:    is_sw = 1'b1;
      OP_BEQ:   begin is_beq = 1'b1; ALUOp = 3'b001; end
      OP_BNE:   begin is_bne = 1'b1; ALUOp = 3'b001; end
      OP_HALT:  is_halt = 1'b1;
`ifdef CU_JUMP_EN
      OP_J:     is_j = 1'b1;
      OP_JAL:   is_jal = 1'b1;
      OP_JR:    is_jr = 1'b1;
`endif
      default:  ;
    endcase
  end

  assign is_alu  = is_r | is_i;
  assign is_jump = is_j | is_jal | is_jr;
  assign illegal = ~(is_alu | is_lw | is_sw | is_beq | is_bne |
                     is_halt | is_jump);

  // Immediate extension and operand routing depend on op only.
  assign ExtSel  = ~((op == OP_ANDI) | (op == OP_ORI));
  assign ALUSrcB = is_i | is_lw | is_sw;
  assign RegDst  = is_r ? 2'b10 :
                   (is_i | is_lw) ? 2'b01 : 2'b00;
  assign state   = state_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    unique case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_alu)              state_d = S_EXE_A;
        else if (is_lw | is_sw)  state_d = S_EXE_LS;
        else if (is_beq | is_bne) state_d = S_EXE_B;
        // halt leaves PC alone so it refetches itself
        PCWre  = illegal | is_jump;
        RegWre = is_jal;
        if (is_j | is_jal) PCSrc = 2'b11;
        else if (is_jr)    PCSrc = 2'b10;
      end
      S_EXE_A:  state_d = S_WB_A;
      S_WB_A: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        mRD     = is_lw;
        mWR     = is_sw;
        PCWre   = is_sw;
        state_d = is_lw ? S_WB_L : S_IF;
      end
      S_WB_L: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
      end
      S_EXE_B: begin
        PCWre = 1'b1;
        if ((is_beq & zero) | (is_bne & ~zero)) PCSrc = 2'b01;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized self-checking bench for control_unit_fsm.
// Honours CU_JUMP_EN the same way as the design.
module tb_control_unit_fsm;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero;
  logic       PCWre, IRWre, ExtSel, ALUSrcB, RegWre;
  logic       mRD, mWR, DBDataSrc;
  logic [2:0] ALUOp, state;
  logic [1:0] RegDst, PCSrc;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  control_unit_fsm dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
    .RegDst(RegDst), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .state(state)
  );

`ifdef CU_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001;
  localparam logic [5:0] ADDIU = 6'b000010, ANDI = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] OR_ = 6'b010011, SLTI = 6'b011100;
  localparam logic [5:0] SW = 6'b100110, LW = 6'b100111;
  localparam logic [5:0] BEQ = 6'b110000, BNE = 6'b110001;
  localparam logic [5:0] J = 6'b111000, JAL = 6'b111010;
  localparam logic [5:0] JR = 6'b111001, HALT = 6'b111111;
  localparam logic [5:0] OPS [16] = '{ADD, SUB, ADDIU, ANDI,
    AND_, ORI, OR_, SLTI, SW, LW, BEQ, BNE, J, JAL, JR, HALT};

  localparam logic [2:0] IF = 3'd0, ID = 3'd1, EXLS = 3'd2;
  localparam logic [2:0] MEM = 3'd3, WBL = 3'd4, EXB = 3'd5;
  localparam logic [2:0] EXA = 3'd6, WBA = 3'd7;

  function automatic bit is_alu(input logic [5:0] o);
    return o inside {ADD, SUB, ADDIU, ANDI, AND_, ORI, OR_, SLTI};
  endfunction

  function automatic bit jmp(input logic [5:0] o);
    return JEN && (o inside {J, JAL, JR});
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return is_alu(o) || (o inside {SW, LW, BEQ, BNE, HALT}) || jmp(o);
  endfunction

  // Instruction latency in cycles
  function automatic int len_of(input logic [5:0] o);
    if (o == LW) return 5;
    if (o == SW || is_alu(o)) return 4;
    if (o == BEQ || o == BNE) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] st_at(input logic [5:0] o, input int k);
    case (k)
      0: return IF;
      1: return ID;
      2: return is_alu(o) ? EXA : (o == LW || o == SW) ? EXLS : EXB;
      3: return is_alu(o) ? WBA : MEM;
      default: return WBL;
    endcase
  endfunction

  function automatic logic [17:0] exp_vec(input logic [2:0] s,
                                          input logic [5:0] o,
                                          input logic z);
    logic pcw, irw, ext, srcb, rw, rd, wr, dbs;
    logic [2:0] aop;
    logic [1:0] dst, psrc;
    pcw = (s == WBA) || (s == WBL) || (s == EXB) ||
          (s == MEM && o == SW) ||
          (s == ID && (!legal(o) || jmp(o)));
    irw = (s == IF);
    ext = !(o == ANDI || o == ORI);
    srcb = o inside {ADDIU, ANDI, ORI, SLTI, LW, SW};
    if (o inside {SUB, BEQ, BNE}) aop = 3'b001;
    else if (o inside {AND_, ANDI}) aop = 3'b100;
    else if (o inside {OR_, ORI}) aop = 3'b011;
    else if (o == SLTI) aop = 3'b110;
    else aop = 3'b000;
    rw = (s == WBA) || (s == WBL) || (s == ID && JEN && o == JAL);
    if (o inside {ADD, SUB, AND_, OR_}) dst = 2'b10;
    else if (o inside {ADDIU, ANDI, ORI, SLTI, LW}) dst = 2'b01;
    else dst = 2'b00;
    rd = (s == MEM && o == LW);
    wr = (s == MEM && o == SW);
    dbs = (s == WBL);
    psrc = 2'b00;
    if (s == EXB && ((o == BEQ && z) || (o == BNE && !z))) psrc = 2'b01;
    if (s == ID && JEN && (o == J || o == JAL)) psrc = 2'b11;
    if (s == ID && JEN && o == JR) psrc = 2'b10;
    return {s, pcw, irw, ext, srcb, aop, rw, dst, rd, wr, dbs, psrc};
  endfunction

  function automatic logic [17:0] got_vec();
    return {state, PCWre, IRWre, ExtSel, ALUSrcB, ALUOp, RegWre,
            RegDst, mRD, mWR, DBDataSrc, PCSrc};
  endfunction

  // Entered just after a falling edge with the DUT in IF.
  // zm: -1 random zero, else fixed; stop: cycles to run (-1 = all).
  task automatic run_instr(input logic [5:0] o, input bit scramble,
                           input int zm, input int stop);
    int n;
    logic [2:0] s;
    logic [5:0] cur;
    logic [17:0] e;
    n = len_of(o);
    if (stop >= 0 && stop < n) n = stop;
    for (int k = 0; k < n; k++) begin
      s = st_at(o, k);
      cur = o;
      if (scramble && s != ID && s != MEM) cur = 6'($urandom);
      op = cur;
      zero = (zm < 0) ? 1'($urandom) : 1'(zm);
      #1;
      e = exp_vec(s, cur, zero);
      vectors++;
      if (got_vec() !== e) begin
        miscompares++;
        $display("FAIL instr op=%b cyc=%0d cur=%b z=%b got=%h exp=%h",
                 o, k, cur, zero, got_vec(), e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    logic [17:0] e;
    Reset = 1'b1;
    op = 6'($urandom);
    zero = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    e = exp_vec(IF, op, zero);
    vectors++;
    if (got_vec() !== e) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", got_vec(), e);
    end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    run_instr(ADD, 1'b0, -1, 2);
    op = ADD;
    #2;
    Reset = 1'b1;
    #1;
    e = exp_vec(IF, op, zero);
    vectors++;
    if (got_vec() !== e) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", got_vec(), e);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if (got_vec() !== e) begin
      miscompares++;
      $display("FAIL reset_hold got=%h exp=%h", got_vec(), e);
    end
    @(negedge CLK);
    Reset = 1'b0;
    run_instr(ADD, 1'b0, -1, -1);
  endtask

  task automatic test_directed();
    run_instr(ORI, 1'b0, -1, -1);
    run_instr(LW, 1'b0, -1, -1);
    run_instr(SW, 1'b0, -1, -1);
    run_instr(BNE, 1'b0, 0, -1);
    run_instr(BNE, 1'b0, 1, -1);
    run_instr(BEQ, 1'b0, 1, -1);
    run_instr(BEQ, 1'b0, 0, -1);
    run_instr(JAL, 1'b0, -1, -1);
    run_instr(J, 1'b0, -1, -1);
    run_instr(JR, 1'b0, -1, -1);
    run_instr(6'b101010, 1'b0, -1, -1);
  endtask

  task automatic test_halt();
    repeat (10) run_instr(HALT, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    logic [5:0] o;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0) o = 6'($urandom);
      else o = OPS[$urandom_range(0, 15)];
      run_instr(o, 1'b0, -1, -1);
    end
  endtask

  task automatic test_op_change();
    for (int i = 0; i < 60; i++)
      run_instr(OPS[$urandom_range(0, 15)], 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_halt();
    test_reset_mid();
    test_random();
    test_op_change();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
